// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
// mem_copy_pkg : shared widths and FSM state encoding for mem_block_copier
// Rev 1.0
// ============================================================================
package mem_copy_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_copy_csum.sv
`default_nettype none
// ============================================================================
// mem_copy_csum : clear/accumulate register summing words read during a copy
// Rev 1.0
// ============================================================================
module mem_copy_csum #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_csum
);

  logic [DATA_W-1:0] csum_q;
  logic [DATA_W-1:0] csum_d;

  // Modulo-2^DATA_W sum; the carry out is intentionally dropped.
  always_comb begin
    csum_d = csum_q;
    if (i_clr) begin
      csum_d = '0;
    end else if (i_acc) begin
      csum_d = csum_q + i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign o_csum = csum_q;

endmodule
`default_nettype wire

// File: rtl/mem_block_copier.sv
`default_nettype none
// ============================================================================
// mem_block_copier : read/write alternating block copy engine for a 256x16 RAM
// Optional checksum accumulator enabled by MEM_BLOCK_COPIER_CSUM_EN.  Rev 1.0
// ============================================================================
module mem_block_copier #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W,
  parameter int DATA_W = mem_copy_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W:0]   LEN,
  input  logic [DATA_W-1:0] RD,
  output logic [ADDR_W-1:0] ADDR,
  output logic              En,
  output logic [DATA_W-1:0] WD,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] CSUM
);

  import mem_copy_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q,   src_d;
  logic [ADDR_W-1:0] dst_q,   dst_d;
  logic [CNT_W-1:0]  rem_q,   rem_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              start_ok;

  assign start_ok = (state_q == IDLE) && START;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          src_d   = SRC;
          dst_d   = DST;
          rem_d   = LEN;
          state_d = (LEN == '0) ? FIN : READ;
        end
      end
      READ: begin
        data_d  = RD;
        state_d = WRITE;
      end
      WRITE: begin
        // Pointers wrap naturally at the address width.
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        rem_d   = rem_q - CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? FIN : READ;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // Memory port decoded from registered state only: no START-to-En path.
  always_comb begin
    ADDR = '0;
    En   = 1'b0;
    WD   = '0;
    BUSY = (state_q != IDLE);
    DONE = (state_q == FIN);
    case (state_q)
      READ: begin
        ADDR = src_q;
      end
      WRITE: begin
        ADDR = dst_q;
        En   = 1'b1;
        WD   = data_q;
      end
      default: begin
        ADDR = '0;
      end
    endcase
  end

`ifdef MEM_BLOCK_COPIER_CSUM_EN
  mem_copy_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_clr  (start_ok),
    .i_acc  (state_q == READ),
    .i_data (RD),
    .o_csum (CSUM)
  );
`else
  assign CSUM = '0;
`endif

endmodule
`default_nettype wire
